// File: rtl/bubble_sort_engine.sv
// In-place bubble-sort engine: N-entry register file with a host load/read port
// and a READ/CMP/SWAP FSM supporting asc/desc order, signed compare and early exit.
module bubble_sort_engine #(
  parameter int DATA_W = 16,
  parameter int N      = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              start,
  input  logic              descending,
  input  logic              signed_mode,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  swap_count,
  output logic [ADDR_W:0]   pass_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CMP, S_SWAP, S_PASS_END, S_FINISH
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [N];
  logic [DATA_W-1:0]   a, b;
  logic [ADDR_W-1:0]   j, limit;
  logic                swapped, desc_q, sgn_q;

  logic [ADDR_W-1:0]   j1;
  logic                last, swap_hit, wr_ok, rd_ok;
  logic signed [DATA_W:0] ax, bx;

  assign j1    = j + ADDR_W'(1);
  assign last  = (j1 == limit);
  // One extra bit makes a single signed compare serve both modes.
  assign ax    = {sgn_q & a[DATA_W-1], a};
  assign bx    = {sgn_q & b[DATA_W-1], b};
  assign swap_hit = desc_q ? (ax < bx) : (ax > bx);
  assign wr_ok = ({1'b0, wr_addr} < (ADDR_W+1)'(N));
  assign rd_ok = ({1'b0, rd_addr} < (ADDR_W+1)'(N));

  // Storage has no reset; rst only blocks writes so an in-flight write is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_IDLE && wr_en && wr_ok)
        mem[wr_addr] <= wr_data;
      else if (state == S_SWAP) begin
        mem[j]  <= b;
        mem[j1] <= a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_ok) rd_data <= mem[rd_addr];
    else            rd_data <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      swap_count <= '0;
      pass_count <= '0;
      j          <= '0;
      limit      <= '0;
      swapped    <= 1'b0;
      desc_q     <= 1'b0;
      sgn_q      <= 1'b0;
      a          <= '0;
      b          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            desc_q     <= descending;
            sgn_q      <= signed_mode;
            j          <= '0;
            limit      <= ADDR_W'(N-1);
            swapped    <= 1'b0;
            swap_count <= '0;
            pass_count <= '0;
            busy       <= 1'b1;
            state      <= S_READ;
          end
        end
        S_READ: begin
          a     <= mem[j];
          b     <= mem[j1];
          state <= S_CMP;
        end
        S_CMP: begin
          if (swap_hit)  state <= S_SWAP;
          else if (last) state <= S_PASS_END;
          else begin
            j     <= j1;
            state <= S_READ;
          end
        end
        S_SWAP: begin
          swapped <= 1'b1;
          if (swap_count != '1) swap_count <= swap_count + CNT_W'(1);
          if (last) state <= S_PASS_END;
          else begin
            j     <= j1;
            state <= S_READ;
          end
        end
        S_PASS_END: begin
          pass_count <= pass_count + (ADDR_W+1)'(1);
          if (!swapped || limit == ADDR_W'(1)) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            limit   <= limit - ADDR_W'(1);
            j       <= '0;
            swapped <= 1'b0;
            state   <= S_READ;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Directed bench: an N=8 engine for reset/early-exit checks and an N=4 engine
// for the small-array sorting, signedness, duplicate and interlock scenarios.
module tb_bubble_sort_engine;

  logic        clk = 1'b0;
  logic        rst, wr_en, start8, start4, descending, signed_mode;
  logic [2:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data8, rd_data4;
  logic        busy8, busy4, done8, done4;
  logic [15:0] swap8, swap4;
  logic [3:0]  pass8;
  logic [2:0]  pass4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bubble_sort_engine #(.DATA_W(16), .N(8), .ADDR_W(3), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data8), .start(start8),
    .descending(descending), .signed_mode(signed_mode),
    .busy(busy8), .done(done8), .swap_count(swap8), .pass_count(pass8));

  bubble_sort_engine #(.DATA_W(16), .N(4), .ADDR_W(2), .CNT_W(16)) u4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data),
    .rd_addr(rd_addr[1:0]), .rd_data(rd_data4), .start(start4),
    .descending(descending), .signed_mode(signed_mode),
    .busy(busy4), .done(done4), .swap_count(swap4), .pass_count(pass4));

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input bit sel8, input logic [2:0] a, output logic [15:0] d);
    rd_addr = a;
    @(posedge clk); #1;
    d = sel8 ? rd_data8 : rd_data4;
  endtask

  task automatic load4(input logic [15:0] v0, v1, v2, v3);
    wr(3'd0, v0); wr(3'd1, v1); wr(3'd2, v2); wr(3'd3, v3);
  endtask

  // Start at edge k, then sample #1 after every edge; cyc = m means cycle k+m.
  task automatic run_sort(input bit sel8, input int inj_cyc, input int rst_cyc,
                          output int done_at, output int ndone, output int end_cyc);
    int cyc;
    logic b, d;
    if (sel8) start8 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; start4 = 1'b0;
    cyc = 1; done_at = 0; ndone = 0; end_cyc = 0;
    while (cyc < 400) begin
      if (cyc == inj_cyc + 1) begin start4 = 1'b0; start8 = 1'b0; wr_en = 1'b0; end
      if (cyc == rst_cyc + 1) rst = 1'b0;
      b = sel8 ? busy8 : busy4;
      d = sel8 ? done8 : done4;
      if (d) begin
        ndone++;
        if (done_at == 0) done_at = cyc;
      end
      if (!b) begin end_cyc = cyc; break; end
      if (cyc == inj_cyc) begin
        if (sel8) start8 = 1'b1; else start4 = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hAAAA;
      end
      if (cyc == rst_cyc) rst = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (end_cyc == 0) begin
      n_bad++;
      $display("FAIL timeout: busy still %0b after %0d cycles, required 0", b, cyc);
    end
  endtask

  task automatic test_reset;
    logic [15:0] d;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'($urandom); wr_addr = 3'($urandom); wr_data = 16'($urandom);
      rd_addr = 3'($urandom); start8 = 1'($urandom); start4 = 1'($urandom);
      descending = 1'($urandom); signed_mode = 1'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0; wr_en = 1'b0; start8 = 1'b0; start4 = 1'b0;
    descending = 1'b0; signed_mode = 1'b0;
    n_cmp++; if (busy8 !== 1'b0)      begin n_bad++; $display("FAIL reset_busy8: got %b, required 0", busy8); end
    n_cmp++; if (done8 !== 1'b0)      begin n_bad++; $display("FAIL reset_done8: got %b, required 0", done8); end
    n_cmp++; if (swap8 !== 16'd0)     begin n_bad++; $display("FAIL reset_swap8: got %0d, required 0", swap8); end
    n_cmp++; if (pass8 !== 4'd0)      begin n_bad++; $display("FAIL reset_pass8: got %0d, required 0", pass8); end
    n_cmp++; if (rd_data8 !== 16'd0)  begin n_bad++; $display("FAIL reset_rd8: got %h, required 0", rd_data8); end
    n_cmp++; if (busy4 !== 1'b0)      begin n_bad++; $display("FAIL reset_busy4: got %b, required 0", busy4); end
    n_cmp++; if (done4 !== 1'b0)      begin n_bad++; $display("FAIL reset_done4: got %b, required 0", done4); end
    n_cmp++; if (swap4 !== 16'd0)     begin n_bad++; $display("FAIL reset_swap4: got %0d, required 0", swap4); end
    n_cmp++; if (pass4 !== 3'd0)      begin n_bad++; $display("FAIL reset_pass4: got %0d, required 0", pass4); end
    n_cmp++; if (rd_data4 !== 16'd0)  begin n_bad++; $display("FAIL reset_rd4: got %h, required 0", rd_data4); end
    wr(3'd2, 16'h1234);
    rd(1'b1, 3'd2, d);
    n_cmp++; if (d !== 16'h1234) begin n_bad++; $display("FAIL reset_wr_rd: got %h, required 1234", d); end
  endtask

  task automatic test_sorted_early_exit;
    int da, nd, ec;
    logic [15:0] d;
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(i + 1));
    descending = 1'b0; signed_mode = 1'b0;
    run_sort(1'b1, -10, -10, da, nd, ec);
    n_cmp++; if (da != 16) begin n_bad++; $display("FAIL sorted_done_cycle: got %0d, required 16", da); end
    n_cmp++; if (nd != 1)  begin n_bad++; $display("FAIL sorted_done_pulses: got %0d, required 1", nd); end
    n_cmp++; if (ec != 17) begin n_bad++; $display("FAIL sorted_busy_drop: got %0d, required 17", ec); end
    n_cmp++; if (swap8 !== 16'd0) begin n_bad++; $display("FAIL sorted_swaps: got %0d, required 0", swap8); end
    n_cmp++; if (pass8 !== 4'd1)  begin n_bad++; $display("FAIL sorted_passes: got %0d, required 1", pass8); end
    for (int i = 0; i < 8; i++) begin
      rd(1'b1, 3'(i), d);
      n_cmp++;
      if (d !== 16'(i + 1)) begin n_bad++; $display("FAIL sorted_mem%0d: got %h, required %h", i, d, 16'(i + 1)); end
    end
  endtask

  task automatic test_reversed;
    int da, nd, ec;
    logic [15:0] d;
    logic [15:0] exp [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    load4(16'd4, 16'd3, 16'd2, 16'd1);
    descending = 1'b0; signed_mode = 1'b0;
    run_sort(1'b0, -10, -10, da, nd, ec);
    n_cmp++; if (da != 22) begin n_bad++; $display("FAIL rev_done_cycle: got %0d, required 22", da); end
    n_cmp++; if (nd != 1)  begin n_bad++; $display("FAIL rev_done_pulses: got %0d, required 1", nd); end
    n_cmp++; if (swap4 !== 16'd6) begin n_bad++; $display("FAIL rev_swaps: got %0d, required 6", swap4); end
    n_cmp++; if (pass4 !== 3'd3)  begin n_bad++; $display("FAIL rev_passes: got %0d, required 3", pass4); end
    for (int i = 0; i < 4; i++) begin
      rd(1'b0, 3'(i), d);
      n_cmp++;
      if (d !== exp[i]) begin n_bad++; $display("FAIL rev_mem%0d: got %h, required %h", i, d, exp[i]); end
    end
  endtask

  task automatic test_signed_unsigned;
    int da, nd, ec;
    logic [15:0] d;
    logic [15:0] exp_s [4] = '{16'd5, 16'd3, 16'hFFFF, 16'h8000};
    logic [15:0] exp_u [4] = '{16'd3, 16'd5, 16'h8000, 16'hFFFF};
    load4(16'hFFFF, 16'd5, 16'h8000, 16'd3);
    descending = 1'b1; signed_mode = 1'b1;
    run_sort(1'b0, -10, -10, da, nd, ec);
    for (int i = 0; i < 4; i++) begin
      rd(1'b0, 3'(i), d);
      n_cmp++;
      if (d !== exp_s[i]) begin n_bad++; $display("FAIL signed_desc_mem%0d: got %h, required %h", i, d, exp_s[i]); end
    end
    load4(16'hFFFF, 16'd5, 16'h8000, 16'd3);
    descending = 1'b0; signed_mode = 1'b0;
    run_sort(1'b0, -10, -10, da, nd, ec);
    for (int i = 0; i < 4; i++) begin
      rd(1'b0, 3'(i), d);
      n_cmp++;
      if (d !== exp_u[i]) begin n_bad++; $display("FAIL unsigned_asc_mem%0d: got %h, required %h", i, d, exp_u[i]); end
    end
  endtask

  task automatic test_duplicates;
    int da, nd, ec;
    logic [15:0] d;
    logic [15:0] exp [4] = '{16'd1, 16'd1, 16'd2, 16'd2};
    load4(16'd2, 16'd1, 16'd2, 16'd1);
    descending = 1'b0; signed_mode = 1'b0;
    run_sort(1'b0, -10, -10, da, nd, ec);
    n_cmp++; if (swap4 !== 16'd3) begin n_bad++; $display("FAIL dup_swaps: got %0d, required 3", swap4); end
    n_cmp++; if (pass4 !== 3'd3)  begin n_bad++; $display("FAIL dup_passes: got %0d, required 3", pass4); end
    for (int i = 0; i < 4; i++) begin
      rd(1'b0, 3'(i), d);
      n_cmp++;
      if (d !== exp[i]) begin n_bad++; $display("FAIL dup_mem%0d: got %h, required %h", i, d, exp[i]); end
    end
  endtask

  task automatic test_busy_interlock;
    int da, nd, ec;
    logic [15:0] d;
    logic [15:0] exp [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    load4(16'd4, 16'd3, 16'd2, 16'd1);
    descending = 1'b0; signed_mode = 1'b0;
    run_sort(1'b0, 3, -10, da, nd, ec);
    n_cmp++; if (da != 22) begin n_bad++; $display("FAIL lock_done_cycle: got %0d, required 22", da); end
    n_cmp++; if (ec != 23) begin n_bad++; $display("FAIL lock_busy_drop: got %0d, required 23", ec); end
    n_cmp++; if (swap4 !== 16'd6) begin n_bad++; $display("FAIL lock_swaps: got %0d, required 6", swap4); end
    for (int i = 0; i < 4; i++) begin
      rd(1'b0, 3'(i), d);
      n_cmp++;
      if (d !== exp[i]) begin n_bad++; $display("FAIL lock_mem%0d: got %h, required %h", i, d, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_sort;
    int da, nd, ec;
    logic [15:0] d;
    logic [15:0] exp_mid [4] = '{16'd3, 16'd4, 16'd2, 16'd1};
    logic [15:0] exp [4]     = '{16'd1, 16'd2, 16'd3, 16'd4};
    load4(16'd4, 16'd3, 16'd2, 16'd1);
    descending = 1'b0; signed_mode = 1'b0;
    run_sort(1'b0, -10, 5, da, nd, ec);
    n_cmp++; if (ec != 6)  begin n_bad++; $display("FAIL rst_busy_drop: got %0d, required 6", ec); end
    n_cmp++; if (nd != 0)  begin n_bad++; $display("FAIL rst_done_pulses: got %0d, required 0", nd); end
    n_cmp++; if (swap4 !== 16'd0) begin n_bad++; $display("FAIL rst_swaps: got %0d, required 0", swap4); end
    for (int i = 0; i < 4; i++) begin
      rd(1'b0, 3'(i), d);
      n_cmp++;
      if (d !== exp_mid[i]) begin n_bad++; $display("FAIL rst_retained_mem%0d: got %h, required %h", i, d, exp_mid[i]); end
    end
    run_sort(1'b0, -10, -10, da, nd, ec);
    n_cmp++; if (nd != 1)  begin n_bad++; $display("FAIL resort_done_pulses: got %0d, required 1", nd); end
    n_cmp++; if (swap4 !== 16'd5) begin n_bad++; $display("FAIL resort_swaps: got %0d, required 5", swap4); end
    n_cmp++; if (pass4 !== 3'd3)  begin n_bad++; $display("FAIL resort_passes: got %0d, required 3", pass4); end
    for (int i = 0; i < 4; i++) begin
      rd(1'b0, 3'(i), d);
      n_cmp++;
      if (d !== exp[i]) begin n_bad++; $display("FAIL resort_mem%0d: got %h, required %h", i, d, exp[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; start8 = 1'b0; start4 = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; descending = 1'b0; signed_mode = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_sorted_early_exit();
    test_reversed();
    test_signed_unsigned();
    test_duplicates();
    test_busy_interlock();
    test_reset_mid_sort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
